// File: rtl/sd_adc_decim.sv
// ---------------------------------------------------------------------------
// sd_adc_decim
//
// First-order delta-sigma ADC front end. The external comparator output is
// brought into the clock domain through a two-flop synchroniser and returned
// as the 1-bit feedback to the external RC integrator. The resulting
// bitstream is decimated by a boxcar filter that counts the ones in each
// window of N = 2**(msbi_g+1) clocks. One unsigned sample is produced per
// window together with a single-cycle valid strobe.
//
// Parameters
//   msbi_g    MSB index of sample_o; window length N = 2**(msbi_g+1)
//
// Ports
//   clk_i     in   1          system clock
//   reset     in   1          asynchronous, active-high reset
//   en_i      in   1          conversion enable; low holds window state cleared
//   comp_i    in   1          asynchronous comparator output
//   fb_o      out  1          feedback bit to the external RC integrator
//   sample_o  out  msbi_g+1   last completed sample, held between strobes
//   valid_o   out  1          one-cycle strobe: sample_o updated this cycle
//
// Build option
//   SD_ADC_AVG4_EN  when defined, sample_o is the mean of the newest four
//                   saturated window results instead of the newest one.
// ---------------------------------------------------------------------------
module sd_adc_decim #(
   parameter int msbi_g = 9
) (
   input  logic              clk_i,
   input  logic              reset,
   input  logic              en_i,
   input  logic              comp_i,
   output logic              fb_o,
   output logic [msbi_g:0]   sample_o,
   output logic              valid_o
);

   localparam logic [msbi_g:0]   ph_last_c = '1;   // N-1
   localparam logic [msbi_g:0]   ph_one_c  = {{msbi_g{1'b0}}, 1'b1};

   logic                s1_q, s1_d;
   logic                s2_q, s2_d;
   logic                fb_q, fb_d;
   logic [msbi_g:0]     ph_q, ph_d;
   logic [msbi_g+1:0]   acc_q, acc_d;
   logic [msbi_g:0]     sample_q, sample_d;
   logic                valid_q, valid_d;

   logic [msbi_g+1:0]   fb_ext;
   logic [msbi_g+1:0]   win_sum;    // acc plus the last bit of the window
   logic [msbi_g:0]     win_sat;    // window result clamped to all-ones
   logic [msbi_g:0]     result;     // value loaded into sample_o on a strobe

   assign fb_ext  = {{(msbi_g+1){1'b0}}, fb_q};
   assign win_sum = acc_q + fb_ext;
   // A window of all ones gives exactly N, which does not fit the sample
   // width; clamp it to full scale rather than letting it wrap to zero.
   assign win_sat = win_sum[msbi_g+1] ? '1 : win_sum[msbi_g:0];

`ifdef SD_ADC_AVG4_EN
   logic [msbi_g:0]     hist_q [3];
   logic [msbi_g:0]     hist_d [3];
   logic [msbi_g+2:0]   avg_sum;

   assign avg_sum = {2'b00, win_sat} + {2'b00, hist_q[0]}
                  + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
   assign result  = avg_sum[msbi_g+2:2];
`else
   assign result  = win_sat;
`endif

   always_comb begin
      // The feedback path runs regardless of en_i so the modulator loop
      // stays locked while conversion is paused.
      s1_d     = comp_i;
      s2_d     = s1_q;
      fb_d     = s2_q;
      ph_d     = ph_q;
      acc_d    = acc_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
`ifdef SD_ADC_AVG4_EN
      hist_d   = hist_q;
`endif
      if (!en_i) begin
         // Any partial window is dropped; sample_o keeps its last value.
         ph_d  = '0;
         acc_d = '0;
      end else if (ph_q == ph_last_c) begin
         ph_d     = '0;
         acc_d    = '0;
         sample_d = result;
         valid_d  = 1'b1;
`ifdef SD_ADC_AVG4_EN
         hist_d[0] = win_sat;
         hist_d[1] = hist_q[0];
         hist_d[2] = hist_q[1];
`endif
      end else begin
         ph_d  = ph_q + ph_one_c;
         acc_d = acc_q + fb_ext;
      end
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         fb_q     <= 1'b0;
         ph_q     <= '0;
         acc_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
`ifdef SD_ADC_AVG4_EN
         for (int i = 0; i < 3; i++) hist_q[i] <= '0;
`endif
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         fb_q     <= fb_d;
         ph_q     <= ph_d;
         acc_q    <= acc_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
`ifdef SD_ADC_AVG4_EN
         hist_q   <= hist_d;
`endif
      end
   end

   assign fb_o     = fb_q;
   assign sample_o = sample_q;
   assign valid_o  = valid_q;

endmodule
